// File: rtl/phase_cal_sweeper.sv
// Sweeps an external clock adjuster through one full phase wrap, finds the longest
// run of positions where the link passes, then steps the adjuster to the run's centre.
module phase_cal_sweeper #(
  parameter int NUM_STEPS     = 56,
  parameter int HOLD_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 64,
  parameter int TEST_CYCLES   = 256,
  parameter int MIN_WINDOW    = 4
) (
  input  logic       clk,
  input  logic       rst_in_n,
  input  logic       start,
  input  logic       pass_in,
  output logic       inc_trigger,
  output logic [5:0] phase_pos,
  output logic       busy,
  output logic       done,
  output logic       cal_ok,
  output logic [5:0] win_start,
  output logic [6:0] win_len
);

  localparam int CNT_MAX0 = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > TEST_CYCLES) ? CNT_MAX0 : TEST_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TEST_LAST   = CNT_W'(TEST_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, TEST, INC_HI, INC_LO, SETTLE, EVAL, CTR_HI, CTR_LO, CTR_SETTLE, DONE
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_last;
  logic             cnt_done;
  logic [6:0]       pos_idx;
  logic             pass_acc;
  logic [6:0]       cur_len;
  logic [5:0]       cur_start;
  logic [6:0]       ctr_rem;
  logic [6:0]       center_cnt;
  logic             sweep_end, win_ok, last_pos, inc_next;
  logic [6:0]       ext_len;
  logic [5:0]       ext_start;

  assign busy       = (state != IDLE) && (state != DONE);
  assign cnt_done   = (cnt == cnt_last);
  assign sweep_end  = (pos_idx == 7'(NUM_STEPS));
  assign last_pos   = (pos_idx == 7'(NUM_STEPS - 1));
  assign center_cnt = {1'b0, win_start} + {1'b0, win_len[6:1]};
  assign win_ok     = (win_len >= 7'(MIN_WINDOW));
  assign inc_next   = (state_next == INC_HI) || (state_next == CTR_HI);

  // Run tracker candidate: current run extended by this position if it passed
  assign ext_len   = pass_acc ? (cur_len + 7'd1) : cur_len;
  assign ext_start = (pass_acc && (cur_len == 7'd0)) ? pos_idx[5:0] : cur_start;

  always_comb begin
    cnt_last = '0;
    case (state)
      TEST:                          cnt_last = TEST_LAST;
      INC_HI, INC_LO, CTR_HI, CTR_LO: cnt_last = HOLD_LAST;
      SETTLE, CTR_SETTLE:            cnt_last = SETTLE_LAST;
      default:                       cnt_last = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = TEST;
      TEST:       if (cnt_done) state_next = EVAL;
      EVAL:       state_next = INC_HI;
      INC_HI:     if (cnt_done) state_next = INC_LO;
      INC_LO:     if (cnt_done) state_next = SETTLE;
      SETTLE: begin
        if (cnt_done) begin
          if (!sweep_end)                          state_next = TEST;
          else if (win_ok && (center_cnt != 7'd0)) state_next = CTR_HI;
          else                                     state_next = DONE;
        end
      end
      CTR_HI:     if (cnt_done) state_next = CTR_LO;
      CTR_LO:     if (cnt_done) state_next = CTR_SETTLE;
      CTR_SETTLE: if (cnt_done) state_next = (ctr_rem == 7'd1) ? DONE : CTR_HI;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state       <= IDLE;
      cnt         <= '0;
      inc_trigger <= 1'b0;
      phase_pos   <= '0;
      done        <= 1'b0;
      cal_ok      <= 1'b0;
      win_start   <= '0;
      win_len     <= '0;
      pos_idx     <= '0;
      pass_acc    <= 1'b0;
      cur_len     <= '0;
      cur_start   <= '0;
      ctr_rem     <= '0;
    end else begin
      state       <= state_next;
      inc_trigger <= inc_next;
      done        <= (state_next == DONE) && (state != DONE);

      if ((state_next != state) || (state == IDLE) || (state == DONE))
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      // Mirror the adjuster: one step per rising edge of inc_trigger
      if (inc_next && !inc_trigger)
        phase_pos <= (phase_pos == 6'(NUM_STEPS - 1)) ? 6'd0 : phase_pos + 6'd1;

      case (state)
        IDLE, DONE: begin
          if (start) begin
            pos_idx   <= '0;
            cur_len   <= '0;
            cur_start <= '0;
            win_start <= '0;
            win_len   <= '0;
            cal_ok    <= 1'b0;
            ctr_rem   <= '0;
          end
        end
        TEST: pass_acc <= pass_acc & pass_in;
        EVAL: begin
          pos_idx <= pos_idx + 7'd1;
          // A fail closes the run; the final position also closes it so runs never wrap
          if (!pass_acc || last_pos) begin
            if (ext_len > win_len) begin
              win_len   <= ext_len;
              win_start <= ext_start;
            end
            cur_len <= '0;
          end else begin
            cur_len   <= ext_len;
            cur_start <= ext_start;
          end
        end
        SETTLE: begin
          if (cnt_done && sweep_end) begin
            cal_ok  <= win_ok;
            ctr_rem <= center_cnt;
          end
        end
        CTR_SETTLE: if (cnt_done) ctr_rem <= ctr_rem - 7'd1;
        default: ;
      endcase

      if ((state != TEST) && (state_next == TEST))
        pass_acc <= 1'b1;
    end
  end

endmodule

// File: tb/tb_phase_cal_sweeper.sv
// Directed bench: a behavioural phase adjuster drives pass_in from a per-position mask.
module tb_phase_cal_sweeper;

  localparam int NS = 8;

  logic       clk = 1'b0;
  logic       rst_in_n = 1'b0;
  logic       start = 1'b0;
  logic       pass_in;
  logic       inc_trigger;
  logic [5:0] phase_pos;
  logic       busy, done, cal_ok;
  logic [5:0] win_start;
  logic [6:0] win_len;

  always #5 clk = ~clk;

  phase_cal_sweeper #(
    .NUM_STEPS(NS), .HOLD_CYCLES(2), .SETTLE_CYCLES(4), .TEST_CYCLES(8), .MIN_WINDOW(2)
  ) dut (
    .clk(clk), .rst_in_n(rst_in_n), .start(start), .pass_in(pass_in),
    .inc_trigger(inc_trigger), .phase_pos(phase_pos), .busy(busy), .done(done),
    .cal_ok(cal_ok), .win_start(win_start), .win_len(win_len)
  );

  // Adjuster model: phase relative to the phase at which the current calibration began
  logic [2:0] adj = 3'd0;
  logic [2:0] base = 3'd0;
  logic [2:0] rel;
  logic [7:0] mask = 8'h00;
  logic       glitch = 1'b0;
  logic       inc_prev = 1'b0;
  int         since = 0;
  int         edges = 0;
  int         checks = 0;
  int         errors = 0;
  int         ne;

  assign rel     = adj - base;
  assign pass_in = mask[rel] && !(glitch && (rel == 3'd3) && (since == 12));

  always @(negedge clk) begin
    if (inc_trigger && !inc_prev) begin
      edges <= edges + 1;
      adj   <= adj + 3'd1;
      since <= 0;
    end else begin
      since <= since + 1;
    end
    inc_prev <= inc_trigger;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_in_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_in_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, int'(done), 1);
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  task automatic run_cal(input string tag, input logic [7:0] m, input logic g, output int n_edges);
    int e0;
    do_reset;
    mask   = m;
    glitch = g;
    base   = adj;
    e0     = edges;
    pulse_start;
    chk({tag, "_busy"}, int'(busy), 1);
    wait_done(tag);
    n_edges = edges - e0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_inc", int'(inc_trigger), 0);
    chk("rst_phase", int'(phase_pos), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_calok", int'(cal_ok), 0);
    chk("rst_wstart", int'(win_start), 0);
    chk("rst_wlen", int'(win_len), 0);
    rst_in_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_inc", int'(inc_trigger), 0);
    chk("idle_busy", int'(busy), 0);

    // Pass at 2..5: window 2/4, centre at 2+2 -> 8+4 edges, phase 4
    run_cal("win25", 8'h3C, 1'b0, ne);
    chk("win25_start", int'(win_start), 2);
    chk("win25_len", int'(win_len), 4);
    chk("win25_ok", int'(cal_ok), 1);
    chk("win25_edges", ne, 12);
    chk("win25_phase", int'(phase_pos), 4);
    repeat (5) @(negedge clk);
    chk("win25_hold_len", int'(win_len), 4);

    run_cal("nopass", 8'h00, 1'b0, ne);
    chk("nopass_len", int'(win_len), 0);
    chk("nopass_ok", int'(cal_ok), 0);
    chk("nopass_edges", ne, 8);
    chk("nopass_phase", int'(phase_pos), 0);

    // Runs {1,2} and {5,6}: tie keeps the earlier run, centre 1+1
    run_cal("tie", 8'h66, 1'b0, ne);
    chk("tie_start", int'(win_start), 1);
    chk("tie_len", int'(win_len), 2);
    chk("tie_ok", int'(cal_ok), 1);
    chk("tie_edges", ne, 10);
    chk("tie_phase", int'(phase_pos), 2);

    // Runs {0} and {6,7}: no merge across the wrap, centre 6+1
    run_cal("wrap", 8'hC1, 1'b0, ne);
    chk("wrap_start", int'(win_start), 6);
    chk("wrap_len", int'(win_len), 2);
    chk("wrap_edges", ne, 15);
    chk("wrap_phase", int'(phase_pos), 7);

    // All pass but one dropped sample at position 3: runs {0..2}, {4..7}
    run_cal("glitch", 8'hFF, 1'b1, ne);
    chk("glitch_start", int'(win_start), 4);
    chk("glitch_len", int'(win_len), 4);
    chk("glitch_edges", ne, 14);
    chk("glitch_phase", int'(phase_pos), 6);
    glitch = 1'b0;

    // Reset while inc_trigger is high
    do_reset;
    mask = 8'h3C;
    pulse_start;
    n = 0;
    while (!inc_trigger && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_inc_seen", int'(inc_trigger), 1);
    rst_in_n = 1'b0;
    #1;
    chk("mid_rst_inc", int'(inc_trigger), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_phase", int'(phase_pos), 0);
    @(negedge clk);
    rst_in_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_inc", int'(inc_trigger), 0);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_done", int'(done), 0);

    // A second start while busy must not restart the sweep
    base = adj;
    ne   = edges;
    pulse_start;
    repeat (20) @(negedge clk);
    chk("ign_busy", int'(busy), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign");
    ne = edges - ne;
    chk("ign_edges", ne, 12);
    chk("ign_start", int'(win_start), 2);
    chk("ign_len", int'(win_len), 4);
    chk("ign_phase", int'(phase_pos), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_cal_sweeper.md
PHASE_CAL_SWEEPER -- requirements
Module: phase_cal_sweeper

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 56, number of phase positions in one full wrap of the adjusted clock (2..63).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, number of clk cycles inc_trigger is held high, and then held low, per increment (>=1).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 64, number of clk cycles waited after inc_trigger falls before testing starts (>=1).
REQ-004 SHALL have parameter TEST_CYCLES, default 256, number of pass_in samples taken per position (>=1).
REQ-005 SHALL have parameter MIN_WINDOW, default 4, minimum passing-run length for a successful calibration.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_in_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: a one-cycle request that begins a calibration.
REQ-009 SHALL have port pass_in, input, 1 bit: link-good indication, already synchronous to clk.
REQ-010 SHALL have port inc_trigger, output, 1 bit: its rising edge commands the clock adjuster to perform one phase increment.
REQ-011 SHALL have port phase_pos, output, 6 bits: tracked current phase position, modulo NUM_STEPS.
REQ-012 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE or DONE.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when calibration completes.
REQ-014 SHALL have port cal_ok, output, 1 bit: high if win_len >= MIN_WINDOW; valid from done onward.
REQ-015 SHALL have port win_start, output, 6 bits: first position of the longest passing run.
REQ-016 SHALL have port win_len, output, 7 bits: length of the longest passing run.

Function
REQ-017 SHALL implement the states IDLE, TEST, INC_HI, INC_LO, SETTLE, EVAL, CTR_HI, CTR_LO, CTR_SETTLE and DONE.
REQ-018 SHALL go from IDLE or DONE to TEST on start, clearing the run trackers, win_start, win_len and cal_ok; phase_pos is not cleared.
REQ-019 SHALL ignore start while busy is high.
REQ-020 SHALL, in TEST, sample pass_in for exactly TEST_CYCLES cycles; the position passes only if every sample is 1.
REQ-021 SHALL use EVAL (1 cycle) to update the run trackers as follows:
- Pass: extend the current run, or open a new run at phase_pos.
- Fail: close the current run.
- A closed run replaces the best run only if it is strictly longer, so ties keep the earliest run.
REQ-022 SHALL run the sweep in this order: test position p, then INC_HI (HOLD_CYCLES), INC_LO (HOLD_CYCLES), SETTLE (SETTLE_CYCLES), then test p+1.
REQ-023 SHALL test exactly NUM_STEPS positions starting from the phase_pos at start, treated as relative position 0.
REQ-024 SHALL, after the last position, close any open run and issue one further increment so the net sweep is NUM_STEPS increments, returning to the start phase.
REQ-025 SHALL NOT merge runs across the sweep wrap; relative positions are used for the window.
REQ-026 SHALL, when cal_ok = 1, issue win_start + win_len/2 increments (floor division) via CTR_HI, CTR_LO and CTR_SETTLE, using the same timing as the sweep.
REQ-027 SHALL, when cal_ok = 0, issue no centering increments.
REQ-028 SHALL increment phase_pos, wrapping NUM_STEPS-1 to 0, on each inc_trigger rising edge.
REQ-029 SHALL drive inc_trigger high only in INC_HI and CTR_HI, directly from a register.
REQ-030 SHALL pulse done for one cycle on entry to DONE; DONE holds the results until the next start.
REQ-031 SHALL report win_start relative to the start phase.

Reset
REQ-032 SHALL, on rst_in_n low, asynchronously enter IDLE and clear inc_trigger, phase_pos, busy, done, cal_ok, win_start, win_len and all counters to 0.
REQ-033 SHALL abandon any calibration in progress on a mid-operation reset; inc_trigger falls immediately, and the adjuster's phase is then unknown to the block.
REQ-034 SHALL resume from IDLE when rst_in_n is released, with no output activity until start.

Verification (NUM_STEPS=8, HOLD_CYCLES=2, SETTLE_CYCLES=4, TEST_CYCLES=8, MIN_WINDOW=2)
REQ-035 SHALL cover: pass_in high only at positions 2..5, start -> win_start=2, win_len=4, cal_ok=1, 12 inc_trigger rising edges total (8 sweep + 4 centering), final phase_pos=4.
REQ-036 SHALL cover: pass_in always 0 -> win_len=0, cal_ok=0, 8 inc edges, final phase_pos=0.
REQ-037 SHALL cover: passing runs {1,2} and {5,6} -> win_start=1, win_len=2 (tie keeps earliest), 10 inc edges in total.
REQ-038 SHALL cover: pass runs at positions 6..7 (open at sweep end) and 0 -> win_start=6, win_len=2, no wrap merge, final phase_pos=7.
REQ-039 SHALL cover: pass_in dropping for one cycle during the test of position 3 within a 0..7 pass pattern -> runs {0..2} and {4..7}, win_start=4, win_len=4.
REQ-040 SHALL cover: rst_in_n asserted during INC_HI -> inc_trigger=0 and busy=0 in the same cycle, and a start pulse during busy is ignored (checked by the edge count).
